sipo_frame_ctrl: RTL and testbench

Sequencer for the SIPO shift/parallel buffer, which is MEMORY_WID entries of DATA_WID bits. It accepts a valid/ready word stream, drives the SIPO shift enable and clear, counts words into frames of up to MEMORY_WID entries, and presents a frame-valid handshake to the parallel consumer. It sits between the serial producer and the SIPO instance, and holds off the producer while a frame awaits consumption.

---
 rtl/sipo_frame_ctrl_if.sv | 27 ++
 rtl/sipo_frame_ctrl.sv | 138 +++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sipo_frame_ctrl_if.sv
// Producer word stream and frame-presentation handshake of the SIPO frame controller.
// master = producer/consumer side, slave = controller side.
interface sipo_frame_ctrl_if #(
    parameter int DATA_WID   = 8,
    parameter int MEMORY_WID = 4
);
    localparam int CNT_WID = $clog2(MEMORY_WID + 1);

    logic                in_valid;
    logic                in_ready;
    logic [DATA_WID-1:0] in_data;
    logic                in_last;
    logic                frame_valid;
    logic                frame_ready;
    logic [CNT_WID-1:0]  frame_count;
    logic                frame_timeout;

    modport master (
        output in_valid, in_data, in_last, frame_ready,
        input  in_ready, frame_valid, frame_count, frame_timeout
    );

    modport slave (
        input  in_valid, in_data, in_last, frame_ready,
        output in_ready, frame_valid, frame_count, frame_timeout
    );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Sequencer for a SIPO buffer: word intake, shift/clear strobes, frame handshake.
// Optional idle timeout that force-closes partial frames: SIPO_CTRL_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no words collected, cnt = 0
// FILL  | 1 <= cnt < MEMORY_WID words collected
// HOLD  | frame presented to consumer, producer stalled
module sipo_frame_ctrl #(
    parameter int DATA_WID    = 8,
    parameter int MEMORY_WID  = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    sipo_frame_ctrl_if.slave    bus,
    output logic                shift_en,
    output logic [DATA_WID-1:0] shift_data,
    output logic                sipo_clr
);
    localparam int CNT_WID = $clog2(MEMORY_WID + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_WID-1:0] cnt_q, cnt_d;
    logic               fv_q, fv_d;
    logic [CNT_WID-1:0] fc_q, fc_d;
    logic               fto_q, fto_d;
    logic               in_ready_int;
    logic               accept;
    logic               expire;

    assign in_ready_int = !rst && (state_q != HOLD);
    assign accept       = bus.in_valid && in_ready_int;

    assign bus.in_ready    = in_ready_int;
    assign bus.frame_valid = fv_q;
    assign bus.frame_count = fc_q;
    assign shift_en        = accept;
    assign shift_data      = bus.in_data;
    assign sipo_clr        = rst || ((state_q == HOLD) && bus.frame_ready);

`ifdef SIPO_CTRL_TIMEOUT_EN
    localparam int TMR_WID = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_WID-1:0] tmr_q, tmr_d;

    // Down-counter reloaded on every accept; terminal count at zero while idle in FILL.
    always_comb begin
        tmr_d = tmr_q;
        if (accept) begin
            tmr_d = TMR_WID'(TIMEOUT_CYC - 1);
        end else if ((state_q == FILL) && (tmr_q != '0)) begin
            tmr_d = tmr_q - TMR_WID'(1);
        end
    end

    assign expire = (state_q == FILL) && !accept && (tmr_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign bus.frame_timeout = fto_q;
`else
    assign expire            = 1'b0;
    assign bus.frame_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fv_d    = fv_q;
        fc_d    = fc_q;
        fto_d   = fto_q;
        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    if ((cnt_q == CNT_WID'(MEMORY_WID - 1)) || bus.in_last) begin
                        state_d = HOLD;
                        fv_d    = 1'b1;
                        fc_d    = cnt_q + CNT_WID'(1);
                        fto_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = FILL;
                        cnt_d   = cnt_q + CNT_WID'(1);
                    end
                end else if (expire) begin
                    state_d = HOLD;
                    fv_d    = 1'b1;
                    fc_d    = cnt_q;
                    fto_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (bus.frame_ready) begin
                    state_d = IDLE;
                    fv_d    = 1'b0;
                    fc_d    = '0;
                    fto_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                fv_d    = 1'b0;
                fc_d    = '0;
                fto_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
            fc_q    <= '0;
            fto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
            fc_q    <= fc_d;
            fto_q   <= fto_d;
        end
    end
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: cycle vector table plus hand-written sequences.
// Covers the timeout path only when SIPO_CTRL_TIMEOUT_EN is defined.
module tb_sipo_frame_ctrl;
    logic       clk;
    logic       rst;
    logic       shift_en;
    logic [7:0] shift_data;
    logic       sipo_clr;

    int total  = 0;
    int passed = 0;

    sipo_frame_ctrl_if #(.DATA_WID(8), .MEMORY_WID(4)) bus ();

    sipo_frame_ctrl #(.DATA_WID(8), .MEMORY_WID(4), .TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .shift_en   (shift_en),
        .shift_data (shift_data),
        .sipo_clr   (sipo_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] d;
        logic       last;
        logic       fr;
        logic       e_ir;
        logic       e_se;
        logic       e_clr;
        logic       e_fv;
        logic [2:0] e_fc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic iv, input logic [7:0] d,
                                input logic last, input logic fr, input logic ir,
                                input logic se, input logic clr, input logic fv,
                                input logic [2:0] fc);
        vec_t v;
        v.rst = r;  v.iv = iv;  v.d = d;  v.last = last;  v.fr = fr;
        v.e_ir = ir; v.e_se = se; v.e_clr = clr; v.e_fv = fv; v.e_fc = fc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic r, input logic iv, input logic [7:0] d,
                         input logic last, input logic fr);
        @(negedge clk);
        rst = r;
        bus.in_valid = iv;
        bus.in_data = d;
        bus.in_last = last;
        bus.frame_ready = fr;
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        drive(v.rst, v.iv, v.d, v.last, v.fr);
        chk($sformatf("v%0d.in_ready", idx), 32'(bus.in_ready), 32'(v.e_ir));
        chk($sformatf("v%0d.shift_en", idx), 32'(shift_en), 32'(v.e_se));
        chk($sformatf("v%0d.sipo_clr", idx), 32'(sipo_clr), 32'(v.e_clr));
        chk($sformatf("v%0d.frame_valid", idx), 32'(bus.frame_valid), 32'(v.e_fv));
        chk($sformatf("v%0d.frame_count", idx), 32'(bus.frame_count), 32'(v.e_fc));
        chk($sformatf("v%0d.frame_timeout", idx), 32'(bus.frame_timeout), 32'd0);
        if (v.e_se) chk($sformatf("v%0d.shift_data", idx), 32'(shift_data), 32'(v.d));
    endtask

    task automatic send_word(input logic [7:0] d, input logic last, input string nm);
        drive(1'b0, 1'b1, d, last, 1'b0);
        chk(nm, 32'(shift_en), 32'd1);
    endtask

    logic [7:0] words[8];

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.in_last = 1'b0;
        bus.frame_ready = 1'b0;

        //              rst  iv   data  last fr   ir   se   clr  fv   fc
        vecs.push_back(mk(1, 0, 8'h00, 0, 0,  0, 0, 1, 0, 3'd0));
        vecs.push_back(mk(1, 1, 8'h11, 0, 0,  0, 0, 1, 0, 3'd0));
        vecs.push_back(mk(0, 1, 8'h11, 0, 0,  1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 0,  1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 8'h33, 0, 0,  1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 8'h44, 0, 0,  1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0,  0, 0, 0, 1, 3'd4));
        vecs.push_back(mk(0, 1, 8'h55, 0, 0,  0, 0, 0, 1, 3'd4));
        vecs.push_back(mk(0, 1, 8'h55, 0, 0,  0, 0, 0, 1, 3'd4));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0,  0, 0, 0, 1, 3'd4));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0,  0, 0, 0, 1, 3'd4));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  0, 0, 1, 1, 3'd4));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  1, 0, 0, 0, 3'd0));
        // two-word frame closed by in_last; third word waits through HOLD
        vecs.push_back(mk(0, 1, 8'hA1, 0, 0,  1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 8'hA2, 1, 0,  1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 8'hA3, 0, 0,  0, 0, 0, 1, 3'd2));
        vecs.push_back(mk(0, 1, 8'hA3, 0, 1,  0, 0, 1, 1, 3'd2));
        vecs.push_back(mk(0, 1, 8'hA3, 0, 0,  1, 1, 0, 0, 3'd0));
        // one-word frame, then reset abandons a partial frame
        vecs.push_back(mk(1, 0, 8'h00, 0, 0,  0, 0, 1, 0, 3'd0));
        vecs.push_back(mk(0, 1, 8'h5C, 1, 0,  1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  0, 0, 1, 1, 3'd1));
        vecs.push_back(mk(0, 1, 8'h01, 0, 0,  1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 8'h02, 0, 0,  1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(1, 1, 8'h03, 0, 0,  0, 0, 1, 0, 3'd0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0,  1, 0, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 8'h04, 0, 0,  1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 8'h05, 0, 0,  1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 8'h06, 0, 0,  1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 8'h07, 0, 0,  1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0,  0, 0, 0, 1, 3'd4));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  0, 0, 1, 1, 3'd4));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0,  1, 0, 0, 0, 3'd0));

        foreach (vecs[i]) run_vec(vecs[i], i);

        // partial frame with no in_last
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        send_word(8'hB1, 1'b0, "to.w1");
        send_word(8'hB2, 1'b0, "to.w2");
        send_word(8'hB3, 1'b0, "to.w3");
`ifdef SIPO_CTRL_TIMEOUT_EN
        for (int k = 1; k <= 17; k++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            chk($sformatf("to.idle%0d.frame_valid", k), 32'(bus.frame_valid), 32'(k == 17));
        end
        chk("to.frame_count", 32'(bus.frame_count), 32'd3);
        chk("to.frame_timeout", 32'(bus.frame_timeout), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("to.consume_clr", 32'(sipo_clr), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("to.cleared_timeout", 32'(bus.frame_timeout), 32'd0);
        // word arriving in the expiry cycle wins
        send_word(8'hC1, 1'b0, "race.w1");
        send_word(8'hC2, 1'b0, "race.w2");
        for (int k = 1; k <= 15; k++) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, "race.w3_at_expiry");
        for (int k = 1; k <= 17; k++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            chk($sformatf("race.idle%0d.frame_valid", k), 32'(bus.frame_valid), 32'(k == 17));
        end
        chk("race.frame_count", 32'(bus.frame_count), 32'd3);
        chk("race.frame_timeout", 32'(bus.frame_timeout), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
`else
        for (int k = 1; k <= 20; k++) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("nto.frame_valid", 32'(bus.frame_valid), 32'd0);
        chk("nto.in_ready", 32'(bus.in_ready), 32'd1);
        send_word(8'hB4, 1'b1, "nto.w4");
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("nto.frame_valid_after_last", 32'(bus.frame_valid), 32'd1);
        chk("nto.frame_count", 32'(bus.frame_count), 32'd4);
        chk("nto.frame_timeout", 32'(bus.frame_timeout), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
`endif

        // toggling producer, consumer always ready: 8 words -> two 4-word frames
        begin
            int  sent = 0;
            int  frames = 0;
            int  bad = 0;
            logic iv = 1'b0;
            logic acc = 1'b0;
            for (int i = 0; i < 8; i++) words[i] = 8'h61 + 8'(i);
            drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
            for (int cyc = 0; cyc < 60 && frames < 2; cyc++) begin
                if (!(iv && !acc)) iv = !iv;
                if (sent >= 8) iv = 1'b0;
                drive(1'b0, iv, (sent < 8) ? words[sent] : 8'h00, 1'b0, 1'b1);
                acc = iv && bus.in_ready;
                if (shift_en !== acc) bad++;
                if (shift_en && sipo_clr) bad++;
                if (shift_en === 1'b1) begin
                    if (shift_data !== words[sent]) bad++;
                    sent++;
                end
                if (bus.frame_valid === 1'b1) begin
                    frames++;
                    chk($sformatf("tog.frame%0d.count", frames), 32'(bus.frame_count), 32'd4);
                end
            end
            chk("tog.shifts", 32'(sent), 32'd8);
            chk("tog.frames", 32'(frames), 32'd2);
            chk("tog.protocol_errors", 32'(bad), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
